arcade_input_ctrl: RTL
======================

// Module: arcade_input_ctrl
// PURPOSE
//  Parametrised player-input front end for arcade cores: decodes hps_io ps2_key events into
//  held-key state, merges per-player MiSTer joysticks, applies control rotation, autofire and
//  coin pulse stretching, and emits registered per-player control words to the game core.
//  Sits between hps_io and the core top. Supports 1-4 players, 1-4 fire buttons, active-high
//  or active-low outputs.
// PARAMETERS
//  NUM_PLAYERS  2     players, 1..4; keyboard maps exist for P1/P2 only, P3/P4 are joystick-only
//  NUM_BUTTONS  2     fire buttons per player, 1..4
//  JOY_SHARE    0     1: OR all joysticks into every player (legacy behaviour); 0: joystick n -> player n
//  ACTIVE_LOW   1     1: every asserted control bit is driven 0
//  COIN_CYCLES  600000  coin pulse length in clk_sys cycles (> 0)
//  AF_DIV       1600000 autofire half-period in clk_sys cycles (> 0)
// PORTS
//  clk_sys      in   1            system clock; the only clock
//  RESET        in   1            synchronous, active-high reset
//  ps2_key      in   11           [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//  joy_in       in   16*NUM_PLAYERS  joystick n at [16n+15:16n]
//  rotate       in   2            0 none, 1 cw, 2 ccw, 3 180
//  af_en        in   NUM_BUTTONS  autofire enable per fire button, all players
//  p_ctrl       out  W*NUM_PLAYERS  W=6+NUM_BUTTONS; per player {coin,start,fire[NB-1:0],up,down,left,right}
//  service      out  1            service/test key state, polarity per ACTIVE_LOW
// BEHAVIOUR
//  Reset: key regs, coin counters, autofire divider/phase cleared; old_toggle <= ps2_key[10]
//   (no spurious event after reset); p_ctrl and service driven inactive (all 1s if ACTIVE_LOW).
//  PS/2: event when ps2_key[10] != old_toggle; at that edge old_toggle updates and the matched key
//   reg <= ps2_key[9]. Unmapped codes ignored. Arrows match with either value of [8].
//  Key map P1: 75/72/6B/74 U/D/L/R, 014 fire0, 029 fire1, 011 fire2, 012 fire3, 005|016 start, 02E coin.
//  Key map P2: 02D/02B/023/034 U/D/L/R, 01C fire0, 01B fire1, 015 fire2, 01D fire3,
//   006|01E start, 036 coin. 02C service.
//  Joystick bits: [0]R [1]L [2]D [3]U, [4+k] fire k, [4+NB] start, [5+NB] coin. Higher bits ignored.
//  Merge: raw = key OR joystick (joystick selection per JOY_SHARE). Opposing directions pass through.
//  Rotation on merged dirs (U,D,L,R out from in):
//   1 = (L,R,D,U); 2 = (R,L,U,D); 3 = (D,U,R,L); 0 = identity. Applied identically to all players.
//  Autofire: free-running divider counts AF_DIV cycles, then toggles af_phase and restarts.
//   Fire k out = raw_k & (af_en[k] ? af_phase : 1).
//  Coin: per player, rising edge of raw coin loads counter with COIN_CYCLES; coin out is high while
//   counter != 0. An edge while counter != 0 is ignored. Holding coin gives exactly one pulse.
//  Latency: all outputs registered; joy_in change -> p_ctrl at edge N+1. ps2 event compared at edge N
//   -> p_ctrl at N+1. Coin out asserts 2 edges after raw coin edge, lasts COIN_CYCLES cycles.
//  RESET mid-pulse or mid-keypress: all state cleared; held keys require a new make event.
// TESTING
//  T1 ps2_key toggle with {pressed=1,code=0x175} -> P1 up asserted (0) 2 cycles later; break code -> released.
//  T2 rotate=1, joy_in P1 bit1 (L) held -> P1 up asserted only; rotate=3 -> P1 right asserted only.
//  T3 COIN_CYCLES=8, key 02E held 50 cycles -> P1 coin asserted exactly 8 cycles, once; re-press -> second pulse.
//  T4 AF_DIV=4, af_en=01, fire0+fire1 held -> fire0 toggles every 4 cycles, fire1 steady asserted.
//  T5 JOY_SHARE=0, joystick 1 fire0 -> only P2 fire0; JOY_SHARE=1 -> both P1 and P2 fire0.
//  T6 RESET pulsed mid-coin pulse with key held -> all outputs inactive next edge, no pulse after release.

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// Player-input front end: PS/2 key state plus joysticks merged into registered per-player
// control words with rotation, autofire and coin pulse stretching.
module arcade_input_ctrl #(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned NUM_BUTTONS = 2,
   parameter int unsigned JOY_SHARE   = 0,
   parameter int unsigned ACTIVE_LOW  = 1,
   parameter int unsigned COIN_CYCLES = 600000,
   parameter int unsigned AF_DIV      = 1600000
) (
   input  logic                                   clk_sys,
   input  logic                                   RESET,
   input  logic [10:0]                            ps2_key,
   input  logic [16*NUM_PLAYERS-1:0]              joy_in,
   input  logic [1:0]                             rotate,
   input  logic [NUM_BUTTONS-1:0]                 af_en,
   output logic [(6+NUM_BUTTONS)*NUM_PLAYERS-1:0] p_ctrl,
   output logic                                   service
);

   localparam int unsigned W    = 6 + NUM_BUTTONS;
   localparam int unsigned CW   = $clog2(COIN_CYCLES + 1);
   localparam int unsigned AW   = $clog2(AF_DIV + 1);
   localparam logic        IDLE = (ACTIVE_LOW != 0);

   // Internal key layout per player: [0]R [1]L [2]D [3]U [7:4]fire [8]start [9]coin
   logic [1:0][9:0]               key_q;
   logic [3:0][9:0]               key_all;
   logic                          svc_q;
   logic                          old_toggle_q;
   logic [1:0][9:0]               key_hit;
   logic                          svc_hit;
   logic [7:0]                    scan;

   logic [15:0]                   joy_or;
   logic [NUM_PLAYERS-1:0][W-1:0] raw;
   logic [NUM_PLAYERS-1:0][3:0]   dir_rot;
   logic [NUM_PLAYERS-1:0][W-1:0] ctrl;
   logic [NUM_PLAYERS-1:0]        raw_coin;

   logic [NUM_PLAYERS-1:0]        coin_prev_q;
   logic [NUM_PLAYERS-1:0][CW-1:0] coin_cnt_q;
   logic [AW-1:0]                 af_cnt_q;
   logic                          af_phase_q;
   logic [W*NUM_PLAYERS-1:0]      p_ctrl_q;
   logic                          service_q;

   logic unused_bits;
   assign unused_bits = ^{key_q, joy_or};

   assign scan    = ps2_key[7:0];
   assign key_all = {20'b0, key_q};

   // Arrows ignore the extended flag; every other mapped key must be non-extended.
   always_comb begin
      key_hit = '0;
      svc_hit = 1'b0;
      case (scan)
         8'h75: key_hit[0][3] = 1'b1;
         8'h72: key_hit[0][2] = 1'b1;
         8'h6B: key_hit[0][1] = 1'b1;
         8'h74: key_hit[0][0] = 1'b1;
         default: begin
            if (!ps2_key[8]) begin
               case (scan)
                  8'h14:        key_hit[0][4] = 1'b1;
                  8'h29:        key_hit[0][5] = 1'b1;
                  8'h11:        key_hit[0][6] = 1'b1;
                  8'h12:        key_hit[0][7] = 1'b1;
                  8'h05, 8'h16: key_hit[0][8] = 1'b1;
                  8'h2E:        key_hit[0][9] = 1'b1;
                  8'h2D:        key_hit[1][3] = 1'b1;
                  8'h2B:        key_hit[1][2] = 1'b1;
                  8'h23:        key_hit[1][1] = 1'b1;
                  8'h34:        key_hit[1][0] = 1'b1;
                  8'h1C:        key_hit[1][4] = 1'b1;
                  8'h1B:        key_hit[1][5] = 1'b1;
                  8'h15:        key_hit[1][6] = 1'b1;
                  8'h1D:        key_hit[1][7] = 1'b1;
                  8'h06, 8'h1E: key_hit[1][8] = 1'b1;
                  8'h36:        key_hit[1][9] = 1'b1;
                  8'h2C:        svc_hit       = 1'b1;
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      joy_or = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         joy_or = joy_or | joy_in[16*p +: 16];
      end
   end

   always_comb begin
      raw      = '0;
      dir_rot  = '0;
      ctrl     = '0;
      raw_coin = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         raw[p] = {key_all[p][9], key_all[p][8], key_all[p][4 +: NUM_BUTTONS], key_all[p][3:0]}
                | ((JOY_SHARE != 0) ? joy_or[W-1:0] : joy_in[16*p +: W]);
         raw_coin[p] = raw[p][W-1];
         // Direction order is {U,D,L,R}
         case (rotate)
            2'd1:    dir_rot[p] = {raw[p][1], raw[p][0], raw[p][2], raw[p][3]};
            2'd2:    dir_rot[p] = {raw[p][0], raw[p][1], raw[p][3], raw[p][2]};
            2'd3:    dir_rot[p] = {raw[p][2], raw[p][3], raw[p][0], raw[p][1]};
            default: dir_rot[p] = raw[p][3:0];
         endcase
         ctrl[p] = {coin_cnt_q[p] != '0,
                    raw[p][4+NUM_BUTTONS],
                    raw[p][4 +: NUM_BUTTONS] & (~af_en | {NUM_BUTTONS{af_phase_q}}),
                    dir_rot[p]};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         old_toggle_q <= ps2_key[10];
         key_q        <= '0;
         svc_q        <= 1'b0;
         coin_prev_q  <= '0;
         coin_cnt_q   <= '0;
         af_cnt_q     <= '0;
         af_phase_q   <= 1'b0;
         p_ctrl_q     <= {(W*NUM_PLAYERS){IDLE}};
         service_q    <= IDLE;
      end else begin
         old_toggle_q <= ps2_key[10];
         if (ps2_key[10] != old_toggle_q) begin
            for (int p = 0; p < 2; p++) begin
               for (int i = 0; i < 10; i++) begin
                  if (key_hit[p][i]) key_q[p][i] <= ps2_key[9];
               end
            end
            if (svc_hit) svc_q <= ps2_key[9];
         end

         if (af_cnt_q == AW'(AF_DIV - 1)) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
         end else begin
            af_cnt_q <= af_cnt_q + AW'(1);
         end

         // A coin edge during a running pulse is swallowed, so holding coin gives one pulse.
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            coin_prev_q[p] <= raw_coin[p];
            if (coin_cnt_q[p] != '0) begin
               coin_cnt_q[p] <= coin_cnt_q[p] - CW'(1);
            end else if (raw_coin[p] && !coin_prev_q[p]) begin
               coin_cnt_q[p] <= CW'(COIN_CYCLES);
            end
         end

         p_ctrl_q  <= ctrl ^ {(W*NUM_PLAYERS){IDLE}};
         service_q <= svc_q ^ IDLE;
      end
   end

   assign p_ctrl  = p_ctrl_q;
   assign service = service_q;

endmodule
